// File: rtl/dh_game_pkg.sv
// Shared game-control types, widths and default parameter values.
//   game_state_e : ctl_game FSM states
//   score_t      : round / duck_idx / round_hits counter bundle
//   sat_inc      : saturating 4-bit increment for the score counters
package dh_game_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned FRAME_CNT_W = 8;

  localparam int unsigned DEF_DUCKS_PER_ROUND = 10;
  localparam int unsigned DEF_PASS_HITS       = 6;
  localparam int unsigned DEF_DELAY_FRAMES    = 60;
  localparam int unsigned DEF_MAX_ROUND       = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH_WAIT,
    ST_PLAYING,
    ST_DUCK_DONE,
    ST_PAUSED,
    ST_GAME_OVER
  } game_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] round;
    logic [CNT_W-1:0] duck_idx;
    logic [CNT_W-1:0] round_hits;
  } score_t;

  localparam score_t SCORE_INIT = '{round: 4'd1, duck_idx: 4'd0, round_hits: 4'd0};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ctl_game_if.sv
// Game-control signal bundle between the game FSM and the rest of the system.
//   master : drives frame/button/duck events, observes game status
//   slave  : ctl_game side, consumes events, drives status and pulses
interface ctl_game_if;
  import dh_game_pkg::*;

  logic             new_frame;
  logic             start_btn;
  logic             pause_sw;
  logic             duck_hit;
  logic             duck_escaped;
  logic             no_ammo;

  logic             game_reset;
  logic             duck_launch;
  logic [CNT_W-1:0] round;
  logic [CNT_W-1:0] duck_idx;
  logic [CNT_W-1:0] round_hits;
  logic             pause;
  logic             looser;
  logic             winner;

  modport master (
    output new_frame, start_btn, pause_sw, duck_hit, duck_escaped, no_ammo,
    input  game_reset, duck_launch, round, duck_idx, round_hits, pause, looser, winner
  );

  modport slave (
    input  new_frame, start_btn, pause_sw, duck_hit, duck_escaped, no_ammo,
    output game_reset, duck_launch, round, duck_idx, round_hits, pause, looser, winner
  );

endinterface

// File: rtl/frame_delay_counter.sv
// Counts new_frame pulses while enabled; done_c fires combinationally on the
// DELAY_FRAMES-th counted pulse and the count wraps to 0 on the next edge.
//   clk, rst   : clock, async active-low reset
//   clear      : synchronous restart of the count (wins over enable)
//   enable     : count new_frame pulses; when low the count is frozen
//   new_frame  : one-cycle frame tick
//   done_c     : delay complete (combinational)
module frame_delay_counter
  import dh_game_pkg::*;
#(
  parameter int unsigned DELAY_FRAMES = DEF_DELAY_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic new_frame,
  output logic done_c
);

  logic [FRAME_CNT_W-1:0] cnt_q;

  assign done_c = enable && new_frame && (cnt_q == FRAME_CNT_W'(DELAY_FRAMES - 1));

  // Frame count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && new_frame) begin
      cnt_q <= done_c ? '0 : cnt_q + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: rtl/ctl_game.sv
// Duck-hunt game sequencer: launches ducks after a frame delay, tallies hits
// and misses per round, advances rounds, and handles pause/restart/game over.
//   clk, rst : 65 MHz clock, async active-low reset
//   bus      : ctl_game_if.slave (events in, registered status/pulses out)
module ctl_game
  import dh_game_pkg::*;
#(
  parameter int unsigned DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int unsigned PASS_HITS       = DEF_PASS_HITS,
  parameter int unsigned DELAY_FRAMES    = DEF_DELAY_FRAMES,
  parameter int unsigned MAX_ROUND       = DEF_MAX_ROUND
) (
  input  logic       clk,
  input  logic       rst,
  ctl_game_if.slave  bus
);

  game_state_e state_q, state_d;
  game_state_e ret_q, ret_d;
  score_t      score_q, score_d;
  logic        game_reset_q, game_reset_d;
  logic        launch_q, launch_d;
  logic        pause_q, pause_d;
  logic        looser_q, looser_d;
  logic        winner_q, winner_d;
  logic        no_ammo_q;

  logic        frame_done_c;
  logic        fd_clear_c;
  logic        fd_enable_c;
  logic        ammo_rise_c;

  assign ammo_rise_c = bus.no_ammo && !no_ammo_q;

  // Frames only count while waiting and not being overridden by pause/restart.
  assign fd_enable_c = ((state_q == ST_LAUNCH_WAIT) || (state_q == ST_DUCK_DONE))
                       && !bus.pause_sw && !bus.start_btn;

  frame_delay_counter #(
    .DELAY_FRAMES (DELAY_FRAMES)
  ) u_frame_delay (
    .clk       (clk),
    .rst       (rst),
    .clear     (fd_clear_c),
    .enable    (fd_enable_c),
    .new_frame (bus.new_frame),
    .done_c    (frame_done_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      score_q      <= SCORE_INIT;
      game_reset_q <= 1'b0;
      launch_q     <= 1'b0;
      pause_q      <= 1'b0;
      looser_q     <= 1'b0;
      winner_q     <= 1'b0;
      no_ammo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      score_q      <= score_d;
      game_reset_q <= game_reset_d;
      launch_q     <= launch_d;
      pause_q      <= pause_d;
      looser_q     <= looser_d;
      winner_q     <= winner_d;
      no_ammo_q    <= bus.no_ammo;
    end
  end

  // Next-state and next-output logic; start_btn overrides everything.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    score_d      = score_q;
    game_reset_d = 1'b0;
    launch_d     = 1'b0;
    pause_d      = 1'b0;
    looser_d     = looser_q;
    winner_d     = winner_q;
    fd_clear_c   = 1'b0;

    if (bus.start_btn) begin
      state_d      = ST_LAUNCH_WAIT;
      score_d      = SCORE_INIT;
      game_reset_d = 1'b1;
      looser_d     = 1'b0;
      winner_d     = 1'b0;
      fd_clear_c   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_LAUNCH_WAIT: begin
          if (bus.pause_sw) begin
            state_d = ST_PAUSED;
            ret_d   = ST_LAUNCH_WAIT;
            pause_d = 1'b1;
          end else if (frame_done_c) begin
            state_d  = ST_PLAYING;
            launch_d = 1'b1;
          end
        end

        ST_PLAYING: begin
          if (bus.pause_sw) begin
            state_d = ST_PAUSED;
            ret_d   = ST_PLAYING;
            pause_d = 1'b1;
          end else if (bus.duck_hit) begin
            // A hit wins over a coincident escape / ammo-out edge.
            score_d.round_hits = sat_inc(score_q.round_hits);
            score_d.duck_idx   = sat_inc(score_q.duck_idx);
            state_d            = ST_DUCK_DONE;
            fd_clear_c         = 1'b1;
          end else if (bus.duck_escaped || ammo_rise_c) begin
            score_d.duck_idx = sat_inc(score_q.duck_idx);
            state_d          = ST_DUCK_DONE;
            fd_clear_c       = 1'b1;
          end
        end

        ST_DUCK_DONE: begin
          if (bus.pause_sw) begin
            state_d = ST_PAUSED;
            ret_d   = ST_DUCK_DONE;
            pause_d = 1'b1;
          end else if (frame_done_c) begin
            if (score_q.duck_idx < CNT_W'(DUCKS_PER_ROUND)) begin
              state_d  = ST_PLAYING;
              launch_d = 1'b1;
            end else if (score_q.round_hits < CNT_W'(PASS_HITS)) begin
              state_d  = ST_GAME_OVER;
              looser_d = 1'b1;
            end else if (score_q.round >= CNT_W'(MAX_ROUND)) begin
              state_d  = ST_GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d            = ST_LAUNCH_WAIT;
              score_d.round      = sat_inc(score_q.round);
              score_d.duck_idx   = '0;
              score_d.round_hits = '0;
              game_reset_d       = 1'b1;
              fd_clear_c         = 1'b1;
            end
          end
        end

        ST_PAUSED: begin
          if (bus.pause_sw) begin
            pause_d = 1'b1;
          end else begin
            state_d = ret_q;
          end
        end

        ST_GAME_OVER: begin
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.game_reset  = game_reset_q;
  assign bus.duck_launch = launch_q;
  assign bus.round       = score_q.round;
  assign bus.duck_idx    = score_q.duck_idx;
  assign bus.round_hits  = score_q.round_hits;
  assign bus.pause       = pause_q;
  assign bus.looser      = looser_q;
  assign bus.winner      = winner_q;

endmodule
